jtag_nibble_sequencer: RTL and testbench

- Converts command bytes arriving over the GPIF byte bus into JTAG bit-cycles on tck/tms/tdi and captures tdo.
- Sits in the cable CPLD between the GPIF byte interface (fd bus plus ctl strobe, wrapped by the top level into a valid/ready pair) and the JTAG pins.
- Each byte carries two nibble commands. The low nibble executes first.
- Captured tdo bits are returned as single-cycle pulses, which the top level routes to PC flag pins.

---
 rtl/jtag_seq_pkg.sv | 15 +
 rtl/jtag_nibble_sequencer_tck_halfper_counter.sv | 28 ++
 rtl/jtag_nibble_sequencer.sv | 136 +++++++++++++
 tb/tb_jtag_nibble_sequencer.sv | 154 +++++++++++++++
 4 files changed

// File: rtl/jtag_seq_pkg.sv
// Shared definitions for the JTAG nibble sequencer: nibble bit positions and FSM states.
package jtag_seq_pkg;

    localparam int unsigned NIB_EXEC = 3;
    localparam int unsigned NIB_CAP  = 2;
    localparam int unsigned NIB_TMS  = 1;
    localparam int unsigned NIB_TDI  = 0;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_LOW  = 2'd1,
        ST_HIGH = 2'd2
    } state_t;

endpackage

// File: rtl/jtag_nibble_sequencer_tck_halfper_counter.sv
// TCK half-period down-counter: load, decrement toward zero, zero flag.
module tck_halfper_counter #(
    parameter int DIV_W = 8
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             load,
    input  logic [DIV_W-1:0] load_val,
    input  logic             dec,
    output logic             zero
);

    logic [DIV_W-1:0] cnt;

    // NOTE: registers use non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk) begin
        if (reset) begin
            cnt <= '0;
        end else if (load) begin
            cnt <= load_val;
        end else if (dec && (cnt != '0)) begin
            cnt <= cnt - 1'b1;
        end
    end

    assign zero = (cnt == '0);

endmodule

// File: rtl/jtag_nibble_sequencer.sv
// Turns command bytes (two nibble commands, low first) into TCK periods on tck/tms/tdi
// and returns sampled tdo as single-cycle pulses.
module jtag_nibble_sequencer
    import jtag_seq_pkg::*;
#(
    parameter int DIV_W = 8
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [7:0]       in_data,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [DIV_W-1:0] clk_div,
    output logic             tck,
    output logic             tms,
    output logic             tdi,
    input  logic             tdo,
    output logic             cap_valid,
    output logic             cap_bit,
    output logic             busy
);

    state_t           state;
    logic [7:0]       byte_q;
    logic [DIV_W-1:0] div_q;
    logic             nib_sel;

    logic [3:0] lo_in, hi_in, hi_nib, cur_nib;
    logic       accept;
    logic       cnt_load, cnt_dec, cnt_zero;
    logic [DIV_W-1:0] cnt_val;

    assign lo_in   = in_data[3:0];
    assign hi_in   = in_data[7:4];
    assign hi_nib  = byte_q[7:4];
    assign cur_nib = nib_sel ? byte_q[7:4] : byte_q[3:0];
    assign accept  = (state == ST_IDLE) && in_valid && in_ready;
    assign busy    = (state != ST_IDLE);

    // NOTE: every always_comb output gets a default first so no latch is inferred.
    always_comb begin
        cnt_load = 1'b0;
        cnt_dec  = 1'b0;
        cnt_val  = div_q;
        case (state)
            ST_IDLE: begin
                // div_q is being written on this edge, so load straight from the port.
                cnt_val  = clk_div;
                cnt_load = accept && (lo_in[NIB_EXEC] || hi_in[NIB_EXEC]);
            end
            default: begin
                cnt_dec  = 1'b1;
                cnt_load = cnt_zero;
            end
        endcase
    end

    tck_halfper_counter #(
        .DIV_W (DIV_W)
    ) u_halfper (
        .clk      (clk),
        .reset    (reset),
        .load     (cnt_load),
        .load_val (cnt_val),
        .dec      (cnt_dec),
        .zero     (cnt_zero)
    );

    // NOTE: only control/output flops need reset values; byte_q and div_q are cleared too
    // since they are cheap, but nothing depends on them before the first accept.
    always_ff @(posedge clk) begin
        if (reset) begin
            state     <= ST_IDLE;
            byte_q    <= '0;
            div_q     <= '0;
            nib_sel   <= 1'b0;
            in_ready  <= 1'b0;
            tck       <= 1'b0;
            tms       <= 1'b1;
            tdi       <= 1'b0;
            cap_valid <= 1'b0;
            cap_bit   <= 1'b0;
        end else begin
            cap_valid <= 1'b0;
            case (state)
                ST_IDLE: begin
                    tck      <= 1'b0;
                    in_ready <= 1'b1;
                    if (accept) begin
                        byte_q <= in_data;
                        div_q  <= clk_div;
                        if (lo_in[NIB_EXEC]) begin
                            nib_sel  <= 1'b0;
                            tms      <= lo_in[NIB_TMS];
                            tdi      <= lo_in[NIB_TDI];
                            in_ready <= 1'b0;
                            state    <= ST_LOW;
                        end else if (hi_in[NIB_EXEC]) begin
                            nib_sel  <= 1'b1;
                            tms      <= hi_in[NIB_TMS];
                            tdi      <= hi_in[NIB_TDI];
                            in_ready <= 1'b0;
                            state    <= ST_LOW;
                        end
                    end
                end
                ST_LOW: begin
                    if (cnt_zero) begin
                        tck       <= 1'b1;
                        cap_bit   <= tdo;
                        cap_valid <= cur_nib[NIB_CAP];
                        state     <= ST_HIGH;
                    end
                end
                ST_HIGH: begin
                    if (cnt_zero) begin
                        tck <= 1'b0;
                        if (!nib_sel && hi_nib[NIB_EXEC]) begin
                            nib_sel <= 1'b1;
                            tms     <= hi_nib[NIB_TMS];
                            tdi     <= hi_nib[NIB_TDI];
                            state   <= ST_LOW;
                        end else begin
                            in_ready <= 1'b1;
                            state    <= ST_IDLE;
                        end
                    end
                end
                default: begin
                    state <= ST_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_jtag_nibble_sequencer.sv
// Directed bench for jtag_nibble_sequencer: per-cycle checks of tck/tms/tdi/handshake
// against expected waveforms derived from the nibble commands and clk_div.
module tb_jtag_nibble_sequencer;

    localparam int DIV_W = 8;

    logic             clk = 1'b0;
    logic             reset;
    logic [7:0]       in_data;
    logic             in_valid;
    logic             in_ready;
    logic [DIV_W-1:0] clk_div;
    logic             tck, tms, tdi, tdo;
    logic             cap_valid, cap_bit, busy;

    int vectors     = 0;
    int miscompares = 0;
    int cap_cnt     = 0;

    always #5 clk = ~clk;

    jtag_nibble_sequencer #(.DIV_W(DIV_W)) dut (
        .clk       (clk),
        .reset     (reset),
        .in_data   (in_data),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .clk_div   (clk_div),
        .tck       (tck),
        .tms       (tms),
        .tdi       (tdi),
        .tdo       (tdo),
        .cap_valid (cap_valid),
        .cap_bit   (cap_bit),
        .busy      (busy)
    );

    always @(negedge clk) if (cap_valid === 1'b1) cap_cnt++;

    initial begin
        #200000;
        $display("FAIL watchdog: observed timeout expected $finish");
        $fatal(1, "watchdog expired");
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %0b expected %0b", tag, obs, exp);
        end
    endtask

    // Packed view {in_ready, busy, tck, tms, tdi, cap_valid}.
    function automatic logic [5:0] outs();
        return {in_ready, busy, tck, tms, tdi, cap_valid};
    endfunction

    // Called in the first cycle after an accept; walks n executed nibbles then the idle cycle.
    task automatic byte_cycles(input string tag, input int d, input int n,
                               input logic t0, input logic i0, input logic c0,
                               input logic t1, input logic i1, input logic c1);
        int p = 2 * (d + 1);
        logic et, ei, ec, etck, ecv;
        for (int k = 1; k <= n * p; k++) begin
            int ph = (k - 1) % p;
            et   = (k > p) ? t1 : t0;
            ei   = (k > p) ? i1 : i0;
            ec   = (k > p) ? c1 : c0;
            etck = (ph > d);
            ecv  = ec && (ph == d + 1);
            chk($sformatf("%s[%0d]", tag, k), 32'(outs()), 32'({1'b0, 1'b1, etck, et, ei, ecv}));
            tick();
        end
        et = (n == 2) ? t1 : t0;
        ei = (n == 2) ? i1 : i0;
        chk($sformatf("%s_idle", tag), 32'(outs()), 32'({1'b1, 1'b0, 1'b0, et, ei, 1'b0}));
    endtask

    initial begin
        int base;
        reset = 1'b1; in_valid = 1'b0; in_data = '0; clk_div = '0; tdo = 1'b0;
        tick(); tick();
        chk("reset_state", 32'(outs()), 32'(6'b000100));
        chk("reset_cap_bit", 32'(cap_bit), 32'd0);
        reset = 1'b0;
        tick();
        chk("ready_after_reset", 32'(outs()), 32'(6'b100100));

        // 0x9B at clk_div 0: tms 1 then 0, tdi 1 throughout, idle at N+5.
        clk_div = 8'd0; in_data = 8'h9B; in_valid = 1'b1;
        tick();
        in_valid = 1'b0;
        byte_cycles("b9B", 0, 2, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0);

        // 0x0C at clk_div 2 with tdo high: one capture pulse on the first high cycle.
        clk_div = 8'd2; in_data = 8'h0C; in_valid = 1'b1; tdo = 1'b1;
        tick();
        in_valid = 1'b0;
        byte_cycles("b0C", 2, 1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1);
        chk("b0C_cap_bit", 32'(cap_bit), 32'd1);

        // 0x00 is consumed with no activity, then 0x80 runs only the high nibble.
        tdo = 1'b0; clk_div = 8'd0; in_data = 8'h00; in_valid = 1'b1;
        tick();
        chk("b00_noop", 32'(outs()), 32'(6'b100000));
        in_data = 8'h80;
        tick();
        in_valid = 1'b0;
        byte_cycles("b80", 0, 1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);

        // Streamed 0xFF, 0xFF at clk_div 1 with in_valid held high.
        clk_div = 8'd1; in_data = 8'hFF; in_valid = 1'b1; tdo = 1'b0;
        base = cap_cnt;
        tick();
        byte_cycles("bFF_1", 1, 2, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1);
        tick();
        byte_cycles("bFF_2", 1, 2, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1);
        in_valid = 1'b0;
        chk("bFF_cap_pulses", 32'(cap_cnt - base), 32'd4);
        chk("bFF_cap_bit", 32'(cap_bit), 32'd0);

        // clk_div moves 1 -> 5 during the first byte; only the next byte sees it.
        clk_div = 8'd1; in_data = 8'h8A; in_valid = 1'b1;
        tick();
        clk_div = 8'd5;
        byte_cycles("div1", 1, 2, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        tick();
        in_valid = 1'b0;
        byte_cycles("div5", 5, 2, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);

        // Reset in the middle of a HIGH phase at clk_div 3.
        clk_div = 8'd3; in_data = 8'h09; in_valid = 1'b1;
        tick();
        in_valid = 1'b0;
        for (int k = 1; k < 6; k++) tick();
        chk("pre_reset_high", 32'(outs()), 32'(6'b011010));
        reset = 1'b1;
        tick();
        reset = 1'b0;
        chk("mid_high_reset", 32'(outs()), 32'(6'b000100));
        tick();
        chk("ready_after_mid_reset", 32'(outs()), 32'(6'b100100));

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
